// File: rtl/store_unit.sv
// store_unit: store datapath. Computes rs1+offset from its private register
// file and writes the low 1/2/4/8 bytes of rs2 into a byte-addressed data
// memory, one byte per cycle, little-endian. Includes a combinational debug
// read port for inspecting memory.
module store_unit #(
    parameter int XLEN      = 64,
    parameter int MEM_BYTES = 256,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rf_we,
    input  logic [4:0]        rf_waddr,
    input  logic [XLEN-1:0]   rf_wdata,
    input  logic              start,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [XLEN-1:0]   offset,
    input  logic [2:0]        funct3,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [XLEN-1:0]   addr,
    output logic [XLEN-1:0]   wdata,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [XLEN-1:0]   dbg_data
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        WRITE,
        DONE
    } state_t;

    state_t state;

    logic [XLEN-1:0] rf [32];
    logic [7:0]      mem [MEM_BYTES];

    logic [XLEN-1:0]   base_q;
    logic [XLEN-1:0]   offset_q;
    logic [2:0]        funct3_q;
    logic [2:0]        cnt;

    logic [XLEN-1:0]   eff_addr;
    logic [2:0]        size_m1;
    logic              misaligned;
    logic              out_of_range;
    logic              calc_err;
    logic [ADDR_W-1:0] write_idx;
    logic [31:0]       dbg_idx;

    // Address arithmetic and legality checks for the latched request
    always_comb begin
        eff_addr = base_q + offset_q;
        case (funct3_q[1:0])
            2'd0:    size_m1 = 3'd0;
            2'd1:    size_m1 = 3'd1;
            2'd2:    size_m1 = 3'd3;
            default: size_m1 = 3'd7;
        endcase
        misaligned   = |(eff_addr[2:0] & size_m1);
        out_of_range = eff_addr >= XLEN'(MEM_BYTES);
        calc_err     = funct3_q[2] | misaligned | out_of_range;
        write_idx    = addr[ADDR_W-1:0] + ADDR_W'(cnt);
    end

    // Register file write port; x0 is never written so it always reads zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (rf_we && (rf_waddr != 5'd0)) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end

    // Store sequencer: latch operands, check the address, walk the bytes, pulse done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
            base_q   <= '0;
            offset_q <= '0;
            funct3_q <= '0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        wdata    <= rf[rs2];
                        base_q   <= rf[rs1];
                        offset_q <= offset;
                        funct3_q <= funct3;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    addr <= eff_addr;
                    cnt  <= 3'd0;
                    if (calc_err) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == size_m1) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Data memory: one byte per cycle while in WRITE, cleared by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (state == WRITE) begin
            mem[write_idx] <= wdata[{cnt, 3'b000} +: 8];
        end
    end

    // Debug read: eight bytes little-endian, bytes past the end of memory read as zero
    always_comb begin
        dbg_data = '0;
        dbg_idx  = '0;
        for (int i = 0; i < 8; i++) begin
            dbg_idx = 32'(dbg_addr) + 32'(i);
            if (dbg_idx < 32'(MEM_BYTES)) begin
                dbg_data[8*i +: 8] = mem[dbg_idx[ADDR_W-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: table-driven and randomized checks of store_unit against a
// byte-array memory model and an array register-file model.
module tb_store_unit;

    localparam int MEM_BYTES = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        start;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] offset;
    logic [2:0]  funct3;
    logic        busy;
    logic        done;
    logic        err;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  dbg_addr;
    logic [63:0] dbg_data;

    store_unit #(.XLEN(64), .MEM_BYTES(MEM_BYTES), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .start(start), .rs1(rs1), .rs2(rs2), .offset(offset), .funct3(funct3),
        .busy(busy), .done(done), .err(err), .addr(addr), .wdata(wdata),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    int pass_count = 0;
    int check_count = 0;

    logic [7:0]  ref_mem [MEM_BYTES];
    logic [63:0] ref_rf [32];

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] off;
        logic [2:0]  f3;
        int          lat;
        logic        err;
        logic [63:0] addr;
    } vec_t;

    vec_t vecs [9];

    int          lat;
    int          exp_lat;
    logic        exp_err;
    logic [63:0] exp_addr;
    logic [63:0] exp_wdata;
    int          done_count;
    int          first_done;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, actual, expected);
    endtask

    // Reference: a store is a size-byte little-endian copy into a byte array
    task automatic model_store(input logic [4:0] s1, input logic [4:0] s2, input logic [63:0] off,
                               input logic [2:0] f3, output int m_lat, output logic m_err,
                               output logic [63:0] m_addr, output logic [63:0] m_wdata);
        logic [63:0] ea;
        int size;
        ea = ref_rf[s1] + off;
        size = 1 << f3[1:0];
        m_err = f3[2] || (ea % 64'(size) != 0) || (ea >= 64'(MEM_BYTES));
        m_lat = m_err ? 2 : 2 + size;
        m_addr = ea;
        m_wdata = ref_rf[s2];
        if (!m_err) begin
            for (int i = 0; i < size; i++) ref_mem[int'(ea) + i] = m_wdata[8*i +: 8];
        end
    endtask

    task automatic writeReg(input logic [4:0] idx, input logic [63:0] val);
        @(negedge clk);
        rf_we = 1'b1; rf_waddr = idx; rf_wdata = val;
        @(negedge clk);
        rf_we = 1'b0;
        if (idx != 5'd0) ref_rf[idx] = val;
    endtask

    task automatic applyStimulus(input logic [4:0] s1, input logic [4:0] s2, input logic [63:0] off,
                                 input logic [2:0] f3, input logic side_we, input logic [4:0] side_idx,
                                 input logic [63:0] side_val, output int n);
        @(negedge clk);
        rs1 = s1; rs2 = s2; offset = off; funct3 = f3; start = 1'b1;
        rf_we = side_we; rf_waddr = side_idx; rf_wdata = side_val;
        @(posedge clk);
        #1;
        start = 1'b0;
        rf_we = 1'b0;
        n = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (done) begin
                n = c;
                break;
            end
        end
        if (n == 0) checkOutput("done timeout", 64'(done), 64'd1);
    endtask

    task automatic check_dbg(input string name, input logic [7:0] a, input logic [63:0] expected);
        dbg_addr = a;
        #1;
        checkOutput(name, dbg_data, expected);
    endtask

    task automatic scan_memory(input string tag);
        logic [63:0] e;
        for (int a = 0; a < MEM_BYTES; a += 8) begin
            for (int b = 0; b < 8; b++) e[8*b +: 8] = ref_mem[a + b];
            check_dbg($sformatf("%s mem@%0h", tag, a), 8'(a), e);
        end
        e = '0;
        for (int b = 0; b < 4; b++) e[8*b +: 8] = ref_mem[252 + b];
        check_dbg($sformatf("%s mem@fc edge", tag), 8'hFC, e);
    endtask

    task automatic run_checked(input logic [4:0] s1, input logic [4:0] s2, input logic [63:0] off,
                               input logic [2:0] f3, input string tag);
        model_store(s1, s2, off, f3, exp_lat, exp_err, exp_addr, exp_wdata);
        applyStimulus(s1, s2, off, f3, 1'b0, 5'd0, 64'd0, lat);
        checkOutput({tag, " lat"}, 64'(lat), 64'(exp_lat));
        checkOutput({tag, " err"}, 64'(err), 64'(exp_err));
        checkOutput({tag, " addr"}, addr, exp_addr);
        checkOutput({tag, " wdata"}, wdata, exp_wdata);
    endtask

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
        for (int i = 0; i < 32; i++) ref_rf[i] = 64'd0;
        reset = 1'b1; rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
        start = 1'b0; rs1 = '0; rs2 = '0; offset = '0; funct3 = '0; dbg_addr = '0;

        // Reset state
        #12;
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset err", 64'(err), 64'd0);
        checkOutput("reset addr", addr, 64'd0);
        checkOutput("reset wdata", wdata, 64'd0);
        check_dbg("reset mem@0", 8'h00, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        writeReg(5'd2, 64'h10);
        writeReg(5'd6, 64'h1122334455667788);
        writeReg(5'd0, 64'hDEADBEEFDEADBEEF);

        vecs[0] = '{5'd2, 5'd6, 64'd8,               3'b011, 10, 1'b0, 64'h18};
        vecs[1] = '{5'd2, 5'd6, 64'd3,               3'b000, 3,  1'b0, 64'h13};
        vecs[2] = '{5'd2, 5'd6, 64'd2,               3'b010, 2,  1'b1, 64'h12};
        vecs[3] = '{5'd0, 5'd6, 64'hFFFFFFFFFFFFFFF8, 3'b011, 2,  1'b1, 64'hFFFFFFFFFFFFFFF8};
        vecs[4] = '{5'd0, 5'd6, 64'h100,             3'b011, 2,  1'b1, 64'h100};
        vecs[5] = '{5'd2, 5'd6, 64'd0,               3'b100, 2,  1'b1, 64'h10};
        vecs[6] = '{5'd0, 5'd6, 64'hF8,              3'b011, 10, 1'b0, 64'hF8};
        vecs[7] = '{5'd2, 5'd6, 64'hEE,              3'b001, 4,  1'b0, 64'hFE};
        vecs[8] = '{5'd0, 5'd0, 64'h20,              3'b011, 10, 1'b0, 64'h20};

        for (int i = 0; i < 9; i++) begin
            model_store(vecs[i].rs1, vecs[i].rs2, vecs[i].off, vecs[i].f3, exp_lat, exp_err, exp_addr, exp_wdata);
            applyStimulus(vecs[i].rs1, vecs[i].rs2, vecs[i].off, vecs[i].f3, 1'b0, 5'd0, 64'd0, lat);
            checkOutput($sformatf("vec%0d lat", i), 64'(lat), 64'(vecs[i].lat));
            checkOutput($sformatf("vec%0d err", i), 64'(err), 64'(vecs[i].err));
            checkOutput($sformatf("vec%0d addr", i), addr, vecs[i].addr);
            checkOutput($sformatf("vec%0d wdata", i), wdata, exp_wdata);
        end

        check_dbg("sd data@18", 8'h18, 64'h1122334455667788);
        check_dbg("sb data@10", 8'h10, 64'h0000000088000000);
        check_dbg("sd data@f8", 8'hF8, 64'h1122334455667788 & 64'h0000FFFFFFFFFFFF | 64'h7788000000000000);
        check_dbg("top data@fc", 8'hFC, 64'h0000000077883344);
        scan_memory("table");

        // Read at start sees the pre-edge register value, not the concurrent write
        writeReg(5'd7, 64'hAAAAAAAAAAAAAAAA);
        model_store(5'd2, 5'd7, 64'h30, 3'b011, exp_lat, exp_err, exp_addr, exp_wdata);
        applyStimulus(5'd2, 5'd7, 64'h30, 3'b011, 1'b1, 5'd7, 64'h5555555555555555, lat);
        ref_rf[7] = 64'h5555555555555555;
        checkOutput("nobypass wdata", wdata, 64'hAAAAAAAAAAAAAAAA);
        check_dbg("nobypass mem@40", 8'h40, 64'hAAAAAAAAAAAAAAAA);

        // Start pulsed mid-store is ignored: exactly one done, on time
        model_store(5'd2, 5'd6, 64'h28, 3'b011, exp_lat, exp_err, exp_addr, exp_wdata);
        @(negedge clk);
        rs1 = 5'd2; rs2 = 5'd6; offset = 64'h28; funct3 = 3'b011; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        done_count = 0;
        first_done = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 4) begin
                start = 1'b1; rs1 = 5'd0; offset = 64'h0; funct3 = 3'b000;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                done_count++;
                if (first_done == 0) first_done = c;
            end
        end
        checkOutput("ignored start done count", 64'(done_count), 64'd1);
        checkOutput("ignored start lat", 64'(first_done), 64'd10);
        checkOutput("ignored start idle", 64'(busy), 64'd0);
        check_dbg("ignored start mem@38", 8'h38, 64'h1122334455667788);

        // Randomized stores against the model
        for (int r = 1; r < 8; r++) writeReg(5'(r), 64'($urandom_range(0, 270)));
        for (int r = 8; r < 32; r++) writeReg(5'(r), {$urandom, $urandom});
        for (int n = 0; n < 40; n++) begin
            logic [4:0]  s1;
            logic [4:0]  s2;
            logic [63:0] off;
            logic [2:0]  f3;
            int          o;
            if ($urandom_range(0, 3) == 0) writeReg(5'($urandom_range(1, 7)), 64'($urandom_range(0, 270)));
            s1 = 5'($urandom_range(0, 7));
            s2 = 5'($urandom_range(0, 31));
            o  = int'($urandom_range(0, 40)) - 20;
            off = {{32{o[31]}}, o};
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            run_checked(s1, s2, off, f3, $sformatf("rand%0d", n));
        end
        scan_memory("random");

        // Reset in the middle of a store clears everything immediately
        @(negedge clk);
        rs1 = 5'd2; rs2 = 5'd6; offset = 64'h50; funct3 = 3'b011; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midreset busy", 64'(busy), 64'd0);
        checkOutput("midreset done", 64'(done), 64'd0);
        checkOutput("midreset addr", addr, 64'd0);
        check_dbg("midreset mem@target", 8'h50, 64'd0);
        check_dbg("midreset mem@18", 8'h18, 64'd0);
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
        for (int i = 0; i < 32; i++) ref_rf[i] = 64'd0;
        @(negedge clk);
        reset = 1'b0;
        run_checked(5'd2, 5'd6, 64'h60, 3'b011, "postreset");
        check_dbg("postreset mem@60", 8'h60, 64'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
